// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath select encodings and trap causes.
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_START     = 4'd0;
  localparam state_t S_FETCH     = 4'd1;
  localparam state_t S_DECODE    = 4'd2;
  localparam state_t S_MEM_ADDR  = 4'd3;
  localparam state_t S_MEM_READ  = 4'd4;
  localparam state_t S_MEM_WRITE = 4'd5;
  localparam state_t S_WB_MEM    = 4'd6;
  localparam state_t S_EXEC_R    = 4'd7;
  localparam state_t S_EXEC_I    = 4'd8;
  localparam state_t S_WB_ALU    = 4'd9;
  localparam state_t S_BRANCH    = 4'd10;
  localparam state_t S_JALR_ADDR = 4'd11;
  localparam state_t S_JUMP      = 4'd12;
  localparam state_t S_TRAP      = 4'd13;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [1:0] ALU_A_PC    = 2'b00;
  localparam logic [1:0] ALU_A_OLDPC = 2'b01;
  localparam logic [1:0] ALU_A_RS1   = 2'b10;

  localparam logic [1:0] ALU_B_RS2  = 2'b00;
  localparam logic [1:0] ALU_B_IMM  = 2'b01;
  localparam logic [1:0] ALU_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_R      = 2'b10;
  localparam logic [1:0] ALU_OP_I      = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MDR    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ILLEGAL     = 2'b01,
    CAUSE_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

  // States whose exit to FETCH completes an instruction.
  function automatic logic is_retire_state(input state_t s);
    case (s)
      S_WB_ALU, S_WB_MEM, S_MEM_WRITE, S_BRANCH: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for one memory access; expired flags the cycle whose
// count has reached MEM_TIMEOUT (never, when MEM_TIMEOUT is 0).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (MEM_TIMEOUT > 32'sd0) ? $clog2(MEM_TIMEOUT + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic HAS_TIMEOUT = (MEM_TIMEOUT > 32'sd0);

  logic [CNT_W-1:0] count_r;
  logic             at_limit_s;

  assign at_limit_s = (count_r == LIMIT);
  assign expired    = HAS_TIMEOUT && at_limit_s;

  // Count wait cycles; saturate at the limit so a disabled timeout never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !at_limit_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style sequencer for a multicycle RV32I datapath with a shared memory
// port, req/ready handshake timeout, retired-instruction counter and traps.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_a_sel,
  output logic [1:0]           alu_b_sel,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 state_r;
  state_t                 state_nxt_s;
  trap_cause_e            cause_nxt_s;
  trap_cause_e            trap_cause_r;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   expired_s;
  logic                   timer_clear_s;
  logic                   timer_en_s;

  // Any state change restarts the count, so each memory state starts from zero.
  assign timer_clear_s = (state_nxt_s != state_r);
  assign timer_en_s    = mem_req && !mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  assign trap       = (state_r == S_TRAP);
  assign trap_cause = trap_cause_r;
  assign instret    = instret_r;

  // Next-state and control decode; outputs depend on state (plus mem_ready in FETCH).
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = CAUSE_NONE;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_a_sel   = ALU_A_PC;
    alu_b_sel   = ALU_B_RS2;
    alu_op      = ALU_OP_ADD;
    result_src  = RES_ALUOUT;
    case (state_r)
      S_START: state_nxt_s = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          alu_a_sel   = ALU_A_PC;
          alu_b_sel   = ALU_B_FOUR;
          result_src  = RES_ALU;
          state_nxt_s = S_DECODE;
        end else if (expired_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_MEM_TIMEOUT;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_a_sel = ALU_A_OLDPC;
        alu_b_sel = ALU_B_IMM;
        case (opcode)
          LOAD, STORE: state_nxt_s = S_MEM_ADDR;
          R_TYPE:      state_nxt_s = S_EXEC_R;
          OP_IMM:      state_nxt_s = S_EXEC_I;
          BRANCH:      state_nxt_s = S_BRANCH;
          JAL:         state_nxt_s = S_JUMP;
          JALR:        state_nxt_s = S_JALR_ADDR;
          default: begin
            state_nxt_s = S_TRAP;
            cause_nxt_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_a_sel = ALU_A_RS1;
        alu_b_sel = ALU_B_IMM;
        if (opcode == STORE) begin
          state_nxt_s = S_MEM_WRITE;
        end else begin
          state_nxt_s = S_MEM_READ;
        end
      end
      S_MEM_READ, S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = (state_r == S_MEM_WRITE);
        adr_src = 1'b1;
        if (mem_ready) begin
          state_nxt_s = (state_r == S_MEM_WRITE) ? S_FETCH : S_WB_MEM;
        end else if (expired_s) begin
          state_nxt_s = S_TRAP;
          cause_nxt_s = CAUSE_MEM_TIMEOUT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_WB_MEM: begin
        result_src  = RES_MDR;
        reg_write   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_EXEC_R: begin
        alu_a_sel   = ALU_A_RS1;
        alu_b_sel   = ALU_B_RS2;
        alu_op      = ALU_OP_R;
        state_nxt_s = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_a_sel   = ALU_A_RS1;
        alu_b_sel   = ALU_B_IMM;
        alu_op      = ALU_OP_I;
        state_nxt_s = S_WB_ALU;
      end
      S_WB_ALU: begin
        result_src  = RES_ALUOUT;
        reg_write   = 1'b1;
        state_nxt_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_a_sel   = ALU_A_RS1;
        alu_b_sel   = ALU_B_RS2;
        alu_op      = ALU_OP_BRANCH;
        pc_write    = branch_taken;
        state_nxt_s = S_FETCH;
      end
      S_JALR_ADDR: begin
        alu_a_sel   = ALU_A_RS1;
        alu_b_sel   = ALU_B_IMM;
        state_nxt_s = S_JUMP;
      end
      S_JUMP: begin
        alu_a_sel   = ALU_A_OLDPC;
        alu_b_sel   = ALU_B_FOUR;
        pc_write    = 1'b1;
        state_nxt_s = S_WB_ALU;
      end
      S_TRAP:  state_nxt_s = S_TRAP;
      default: state_nxt_s = S_START;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_START;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Trap cause is captured on entry to TRAP and then held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_cause_r <= CAUSE_NONE;
    end else if ((state_r != S_TRAP) && (state_nxt_s == S_TRAP)) begin
      trap_cause_r <= cause_nxt_s;
    end else begin
      trap_cause_r <= trap_cause_r;
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_r <= '0;
    end else if (is_retire_state(state_r) && (state_nxt_s == S_FETCH)) begin
      instret_r <= instret_r + INSTRET_W'(1);
    end else begin
      instret_r <= instret_r;
    end
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM that sequences a multicycle RV32I datapath: shared ALU, a single unified instruction/data memory, IR/OldPC/ALUOut/MDR registers.
- Decodes the same opcode set as the single-cycle main control unit: R, LOAD, STORE, BRANCH, OP-IMM, JAL, JALR.
- Drives a req/ready memory handshake with a timeout.
- Counts retired instructions and traps on illegal opcodes.

Parameters:
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before trap; 0 disables the timeout.
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  comparison result from branch unit, valid in BRANCH
- mem_ready  in  1  memory completes access this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- adr_src  out  1  0=PC, 1=ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  PC update
- reg_write  out  1  register file write
- alu_a_sel  out  2  00=PC, 01=OldPC, 10=rs1
- alu_b_sel  out  2  00=rs2, 01=imm, 10=const 4
- alu_op  out  2  00=add, 01=branch, 10=R, 11=I (ALU controller encoding)
- result_src  out  2  00=ALUOut, 01=MDR, 10=ALU result
- trap  out  1  sticky halt indicator
- trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout
- instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state=START, wait counter=0, instret=0, trap_cause=00.
- START: all outputs 0. Next cycle goes to FETCH.
- Default in every state: all strobes 0, selects 00.
- FETCH: mem_req=1, adr_src=0.
  - On mem_ready: ir_write=1, alu_a=PC, alu_b=4, alu_op=00, result_src=10, pc_write=1, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_a=OldPC, alu_b=imm, alu_op=00 (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BRANCH
  - 1101111 -> JUMP
  - 1100111 -> JALR_ADDR
  - any other -> TRAP with cause 01
- MEM_ADDR: alu_a=rs1, alu_b=imm, alu_op=00. LOAD -> MEM_READ; STORE -> MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. On mem_ready -> WB_MEM.
- MEM_WRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready -> FETCH (retire).
- WB_MEM: result_src=01, reg_write=1, then FETCH (retire).
- EXEC_R: alu_a=rs1, alu_b=rs2, alu_op=10, then WB_ALU.
- EXEC_I: alu_a=rs1, alu_b=imm, alu_op=11, then WB_ALU.
- WB_ALU: result_src=00, reg_write=1, then FETCH (retire).
- BRANCH: alu_a=rs1, alu_b=rs2, alu_op=01, result_src=00, pc_write=branch_taken, then FETCH (retire).
- JALR_ADDR: alu_a=rs1, alu_b=imm, alu_op=00, then JUMP.
- JUMP: alu_a=OldPC, alu_b=4, alu_op=00, result_src=00, pc_write=1, then WB_ALU (rd <= OldPC+4). LSB clearing of the target is the datapath's job.
- TRAP: all strobes 0, trap=1. Absorbing until reset; trap_cause holds its value.
- Latency with zero wait states:
  - R/I/JALR: 4/4/5 cycles (FETCH..WB).
  - LOAD: 5. STORE: 4. BRANCH: 3. JAL: 4.
- Memory handshake:
  - mem_req, mem_we and adr_src stay stable until a cycle with mem_req=1 and mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready on the first request cycle gives a zero-wait access.
- Timeout:
  - The wait counter clears on entry to every memory state and increments each cycle mem_req=1 and mem_ready=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT while mem_ready=0, go to TRAP with cause 10.
  - mem_ready arriving in that same cycle wins: the access completes, no trap.
- instret:
  - Increments by 1 on each transition into FETCH from WB_ALU, WB_MEM, MEM_WRITE or BRANCH. JUMP and JALR retire via WB_ALU.
  - Wraps modulo 2^INSTRET_W. Never increments in TRAP.
- Reset mid-access (rst_n low during any state): immediate return to START. mem_req drops asynchronously and the access is abandoned.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum
  - opcode constants (R_TYPE, LOAD, STORE, BRANCH, OP_IMM, JAL, JALR)
  - alu_a/alu_b/result_src/alu_op encodings
  - trap_cause encodings
- One sub-module, mem_wait_timer: counter with clear/enable inputs and an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset release, mem_ready tied 1, opcode=0110011 -> START, FETCH, DECODE, EXEC_R, WB_ALU (reg_write=1), FETCH; instret=1 after 5 cycles.
- LOAD 0000011, mem_ready low 3 cycles in MEM_READ -> mem_req/adr_src=1 held 4 cycles, WB_MEM with result_src=01, instret +1.
- BRANCH with branch_taken=0 then 1 -> pc_write=0 then 1 in BRANCH; both retire, instret +2.
- opcode=0110111 (unsupported) -> TRAP, trap=1, trap_cause=01, no strobes thereafter, instret frozen.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> TRAP with cause 10 on the 5th request cycle. Repeat with mem_ready on that cycle -> DECODE, no trap.
- rst_n pulsed low mid-MEM_WRITE -> mem_req and mem_we drop without waiting for clk; state START; instret=0.
